// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART with FWFT TX/RX FIFOs, runtime baud divisor, parity, stop bits and sticky errors
module uart_fifo #(
   parameter int DATA_BITS   = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 10417
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_cfg_wr,
   input  logic [15:0]                   i_baud_div,
   input  logic                          i_parity_en,
   input  logic                          i_parity_odd,
   input  logic                          i_two_stop,
   input  logic                          i_tx_valid,
   input  logic [DATA_BITS-1:0]          i_tx_data,
   output logic                          o_tx_ready,
   output logic                          o_rx_valid,
   output logic [DATA_BITS-1:0]          o_rx_data,
   input  logic                          i_rx_ready,
   input  logic                          i_rx,
   output logic                          o_tx,
   output logic [$clog2(FIFO_DEPTH):0]   o_tx_count,
   output logic [$clog2(FIFO_DEPTH):0]   o_rx_count,
   output logic                          o_idle,
   output logic                          o_parity_err,
   output logic                          o_frame_err,
   output logic                          o_overrun,
   input  logic                          i_err_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP1, T_STOP2} tx_state_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
   tx_state_t ts, ts_nxt, tx_again;
   rx_state_t rs, rs_nxt;
   logic [15:0] div, tcnt, rcnt;
   logic par_en, par_odd, two_stop;
   logic [DATA_BITS-1:0] tmem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] rmem [FIFO_DEPTH];
   logic [AW-1:0] twp, trp, rwp, rrp;
   logic [DATA_BITS-1:0] tword, rshift;
   logic [3:0] tbit, rbit;
   logic tpar, rpar, s1, s2, s3;
   logic ttick, rtick, tpush, tpop, rpush, rpop, rdone, full, perr_new, ferr_new, good, ovr_new;
   assign o_idle = ts == T_IDLE && o_tx_count == '0 && rs == R_IDLE;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div <= 16'(DEFAULT_DIV);
         par_en <= 1'b0;
         par_odd <= 1'b0;
         two_stop <= 1'b0;
      end else if (i_cfg_wr && o_idle) begin
         div <= (i_baud_div < 16'd4) ? 16'd4 : i_baud_div;
         par_en <= i_parity_en;
         par_odd <= i_parity_odd;
         two_stop <= i_two_stop;
      end
   end
   assign o_tx_ready = o_tx_count != FULL;
   assign o_rx_valid = o_rx_count != '0;
   assign tpush = i_tx_valid && o_tx_ready;
   assign rpop = o_rx_valid && i_rx_ready;
   assign full = o_rx_count == FULL;
   assign o_rx_data = o_rx_valid ? rmem[rrp] : '0;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         twp <= '0;
         trp <= '0;
         rwp <= '0;
         rrp <= '0;
         o_tx_count <= '0;
         o_rx_count <= '0;
      end else begin
         if (tpush) begin
            tmem[twp] <= i_tx_data;
            twp <= twp + 1'b1;
         end
         if (rpush) begin
            rmem[rwp] <= rshift;
            rwp <= rwp + 1'b1;
         end
         trp <= trp + AW'(tpop);
         rrp <= rrp + AW'(rpop);
         o_tx_count <= o_tx_count + CW'(tpush) - CW'(tpop);
         o_rx_count <= o_rx_count + CW'(rpush) - CW'(rpop);
      end
   end
   assign ttick = tcnt == div - 16'd1;
   assign tx_again = (o_tx_count != '0) ? T_START : T_IDLE;
   always_comb begin
      ts_nxt = ts;
      case (ts)
         T_IDLE:   ts_nxt = tx_again;
         T_START:  ts_nxt = ttick ? T_DATA : T_START;
         T_DATA:   ts_nxt = (ttick && tbit == LAST) ? (par_en ? T_PARITY : T_STOP1) : T_DATA;
         T_PARITY: ts_nxt = ttick ? T_STOP1 : T_PARITY;
         T_STOP1:  ts_nxt = !ttick ? T_STOP1 : two_stop ? T_STOP2 : tx_again;
         default:  ts_nxt = ttick ? tx_again : T_STOP2;
      endcase
   end
   // the final stop bit pops the next word directly, so back-to-back frames have no gap
   assign tpop = ts_nxt == T_START && ts != T_START;
   assign o_tx = (ts == T_START) ? 1'b0 : (ts == T_DATA) ? tword[0] : (ts == T_PARITY) ? tpar : 1'b1;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ts <= T_IDLE;
         tcnt <= '0;
         tbit <= '0;
         tword <= '0;
         tpar <= 1'b0;
      end else begin
         ts <= ts_nxt;
         tcnt <= (ts == T_IDLE || ttick) ? '0 : tcnt + 16'd1;
         tbit <= (ts != T_DATA) ? '0 : tbit + {3'b0, ttick};
         if (tpop) begin
            tword <= tmem[trp];
            tpar <= (^tmem[trp]) ^ par_odd;
         end else if (ts == T_DATA && ttick) begin
            tword <= tword >> 1;
         end
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         {s1, s2, s3} <= 3'b111;
      end else begin
         s1 <= i_rx;
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign rtick = rcnt == ((rs == R_START) ? (div >> 1) - 16'd1 : div - 16'd1);
   always_comb begin
      rs_nxt = rs;
      case (rs)
         R_IDLE:   rs_nxt = (s3 && !s2) ? R_START : R_IDLE;
         R_START:  rs_nxt = !rtick ? R_START : s2 ? R_IDLE : R_DATA;
         R_DATA:   rs_nxt = (rtick && rbit == LAST) ? (par_en ? R_PARITY : R_STOP) : R_DATA;
         R_PARITY: rs_nxt = rtick ? R_STOP : R_PARITY;
         default:  rs_nxt = rtick ? R_IDLE : R_STOP;
      endcase
   end
   assign rdone = rs == R_STOP && rtick;
   assign ferr_new = rdone && !s2;
   assign perr_new = rdone && s2 && par_en && (rpar ^ (^rshift) ^ par_odd);
   assign good = rdone && s2 && !perr_new;
   assign ovr_new = good && full && !rpop;
   assign rpush = good && (!full || rpop);
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rs <= R_IDLE;
         rcnt <= '0;
         rbit <= '0;
         rshift <= '0;
         rpar <= 1'b0;
      end else begin
         rs <= rs_nxt;
         rcnt <= (rs == R_IDLE || rtick) ? '0 : rcnt + 16'd1;
         rbit <= (rs != R_DATA) ? '0 : rbit + {3'b0, rtick};
         if (rs == R_DATA && rtick) rshift <= {s2, rshift[DATA_BITS-1:1]};
         if (rs == R_PARITY && rtick) rpar <= s2;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_parity_err <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_parity_err <= (o_parity_err && !i_err_clr) || perr_new;
         o_frame_err <= (o_frame_err && !i_err_clr) || ferr_new;
         o_overrun <= (o_overrun && !i_err_clr) || ovr_new;
      end
   end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: table-driven RX frame vectors plus directed loopback, flow-control, overrun, glitch and reset sequences
module tb_uart_fifo;
   localparam int BIT = 16;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, cfg_wr, parity_en, parity_odd, two_stop, tx_valid, rx_ready, loop, drv, err_clr;
   logic [15:0] baud_div;
   logic [7:0] tx_data, rx_data;
   logic tx_ready, rx_valid, tx, rx_line, idle, perr, ferr, ovr;
   logic [4:0] tx_count, rx_count;
   logic drv4, rx_ready4, tx4, tx_ready4, rx_valid4, idle4, perr4, ferr4, ovr4;
   logic [7:0] rx_data4;
   logic [2:0] tx_count4, rx_count4;
   assign rx_line = loop ? tx : drv;
   uart_fifo dut (
      .i_clk(clk), .i_rst(rst), .i_cfg_wr(cfg_wr), .i_baud_div(baud_div),
      .i_parity_en(parity_en), .i_parity_odd(parity_odd), .i_two_stop(two_stop),
      .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
      .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
      .i_rx(rx_line), .o_tx(tx), .o_tx_count(tx_count), .o_rx_count(rx_count),
      .o_idle(idle), .o_parity_err(perr), .o_frame_err(ferr), .o_overrun(ovr),
      .i_err_clr(err_clr)
   );
   uart_fifo #(.FIFO_DEPTH(4), .DEFAULT_DIV(16)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_cfg_wr(1'b0), .i_baud_div(16'd0),
      .i_parity_en(1'b0), .i_parity_odd(1'b0), .i_two_stop(1'b0),
      .i_tx_valid(1'b0), .i_tx_data(8'h00), .o_tx_ready(tx_ready4),
      .o_rx_valid(rx_valid4), .o_rx_data(rx_data4), .i_rx_ready(rx_ready4),
      .i_rx(drv4), .o_tx(tx4), .o_tx_count(tx_count4), .o_rx_count(rx_count4),
      .o_idle(idle4), .o_parity_err(perr4), .o_frame_err(ferr4), .o_overrun(ovr4),
      .i_err_clr(1'b0)
   );
   int checks = 0, errors = 0, cyc = 0, c0 = 0, mon_bit = BIT;
   int falls[$];
   logic mon_p = 1'b1;
   always @(posedge clk) cyc <= cyc + 1;
   // frame-start monitor: after a start edge, ignore the line until mid stop bit
   initial forever begin
      @(negedge clk);
      if (mon_p && !tx) begin
         falls.push_back(cyc);
         repeat (mon_bit * 19 / 2 - 1) @(negedge clk);
      end
      mon_p = tx;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic put_bit(input logic b, input bit to4);
      if (to4) drv4 = b;
      else drv = b;
      tick(BIT);
   endtask
   task automatic send(input logic [7:0] d, input bit pe, po, ts, bp, bs, to4);
      put_bit(1'b0, to4);
      for (int i = 0; i < 8; i++) put_bit(d[i], to4);
      if (pe) put_bit((^d) ^ po ^ bp, to4);
      put_bit(!bs, to4);
      if (ts) put_bit(1'b1, to4);
   endtask
   task automatic set_cfg(input logic [15:0] dv, input bit pe, po, ts);
      cfg_wr = 1'b1;
      baud_div = dv;
      parity_en = pe;
      parity_odd = po;
      two_stop = ts;
      tick(1);
      cfg_wr = 1'b0;
   endtask
   typedef struct {
      logic [7:0] data;
      logic [4:0] fmt;
      logic [2:0] exp;
   } vec_t;
   vec_t vecs[8];
   logic [7:0] words[8];
   initial begin
      // fmt = {parity_en, parity_odd, two_stop, bad_parity, bad_stop}; exp = {stored, parity_err, frame_err}
      vecs[0] = '{8'h55, 5'b00000, 3'b100};
      vecs[1] = '{8'h81, 5'b10000, 3'b100};
      vecs[2] = '{8'hA5, 5'b11100, 3'b100};
      vecs[3] = '{8'h3C, 5'b11110, 3'b010};
      vecs[4] = '{8'h0F, 5'b11101, 3'b001};
      vecs[5] = '{8'hFF, 5'b10010, 3'b010};
      vecs[6] = '{8'h00, 5'b00100, 3'b100};
      vecs[7] = '{8'hC3, 5'b10011, 3'b001};
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      rst = 1'b1;
      {cfg_wr, parity_en, parity_odd, two_stop, tx_valid, rx_ready, loop, err_clr, rx_ready4} = '0;
      drv = 1'b1;
      drv4 = 1'b1;
      baud_div = 16'd0;
      tx_data = 8'h00;
      tick(3);
      rst = 1'b0;
      chk("rst_tx", 32'(tx), 1);
      chk("rst_tx_ready", 32'(tx_ready), 1);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_tx_count", 32'(tx_count), 0);
      chk("rst_rx_count", 32'(rx_count), 0);
      chk("rst_flags", 32'({perr, ferr, ovr}), 0);
      chk("rst_rx_data", 32'(rx_data), 0);
      chk("rst_rx_count4", 32'(rx_count4), 0);
      set_cfg(16'd16, 1'b0, 1'b0, 1'b0);
      loop = 1'b1;
      falls.delete();
      c0 = cyc;
      tx_valid = 1'b1;
      tx_data = 8'hA5;
      tick(1);
      tx_data = 8'h3C;
      tick(1);
      tx_data = 8'hFF;
      tick(1);
      tx_valid = 1'b0;
      for (int k = 0; k < 700 && rx_count != 5'd3; k++) tick(1);
      chk("loop_rx_count", 32'(rx_count), 3);
      chk("loop_starts", falls.size(), 3);
      if (falls.size() >= 3) begin
         chk("loop_first_start", falls[0] - c0, 2);
         chk("loop_frame1_len", falls[1] - falls[0], 160);
         chk("loop_frame2_len", falls[2] - falls[1], 160);
      end
      chk("loop_word0", 32'(rx_data), 32'h A5);
      rx_ready = 1'b1;
      tick(1);
      chk("loop_word1", 32'(rx_data), 32'h3C);
      tick(1);
      chk("loop_word2", 32'(rx_data), 32'hFF);
      tick(1);
      rx_ready = 1'b0;
      chk("loop_empty", 32'(rx_valid), 0);
      chk("loop_flags", 32'({perr, ferr, ovr}), 0);
      tick(10);
      chk("loop_idle", 32'(idle), 1);
      loop = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_cfg(16'd16, vecs[i].fmt[4], vecs[i].fmt[3], vecs[i].fmt[2]);
         send(vecs[i].data, vecs[i].fmt[4], vecs[i].fmt[3], vecs[i].fmt[2], vecs[i].fmt[1], vecs[i].fmt[0], 1'b0);
         tick(4);
         chk($sformatf("vec%0d_count", i), 32'(rx_count), 32'(vecs[i].exp[2]));
         if (vecs[i].exp[2]) chk($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].data));
         chk($sformatf("vec%0d_perr", i), 32'(perr), 32'(vecs[i].exp[1]));
         chk($sformatf("vec%0d_ferr", i), 32'(ferr), 32'(vecs[i].exp[0]));
         chk($sformatf("vec%0d_ovr", i), 32'(ovr), 0);
         rx_ready = 1'b1;
         err_clr = 1'b1;
         tick(1);
         rx_ready = 1'b0;
         err_clr = 1'b0;
         chk($sformatf("vec%0d_cleared", i), 32'({rx_valid, perr, ferr, ovr}), 0);
      end
      set_cfg(16'd16, 1'b0, 1'b0, 1'b0);
      drv = 1'b0;
      tick(4);
      drv = 1'b1;
      tick(40);
      chk("glitch_count", 32'(rx_count), 0);
      chk("glitch_flags", 32'({perr, ferr, ovr}), 0);
      send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(4);
      chk("post_glitch_data", 32'(rx_data), 32'h5A);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(words[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(4);
      chk("ovr_count", 32'(rx_count4), 4);
      chk("ovr_flag", 32'(ovr4), 1);
      chk("ovr_other_flags", 32'({perr4, ferr4}), 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovr_word%0d", i), 32'(rx_data4), 32'(words[i]));
         rx_ready4 = 1'b1;
         tick(1);
         rx_ready4 = 1'b0;
      end
      chk("ovr_drained", 32'(rx_count4), 0);
      c0 = cyc;
      tx_valid = 1'b1;
      tx_data = 8'h00;
      tick(1);
      tx_valid = 1'b0;
      tick(4);
      for (int i = 0; i < 16; i++) begin
         tx_valid = 1'b1;
         tick(1);
      end
      chk("fill_count", 32'(tx_count), 16);
      chk("fill_ready", 32'(tx_ready), 0);
      for (int k = 0; k < 300 && !tx_ready; k++) tick(1);
      chk("w17_ready_cycle", cyc, c0 + 162);
      tick(1);
      tx_valid = 1'b0;
      chk("w17_count", 32'(tx_count), 16);
      tick(30);
      chk("pre_rst_tx", 32'(tx), 0);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_tx", 32'(tx), 1);
      chk("mid_rst_tx_count", 32'(tx_count), 0);
      chk("mid_rst_rx_count", 32'(rx_count), 0);
      chk("mid_rst_ready_idle", 32'({tx_ready, idle}), 3);
      rst = 1'b0;
      tick(200);
      set_cfg(16'd2, 1'b0, 1'b0, 1'b0);
      mon_bit = 4;
      falls.delete();
      c0 = cyc;
      tx_valid = 1'b1;
      tx_data = 8'h55;
      tick(1);
      tx_data = 8'hAA;
      tick(1);
      tx_valid = 1'b0;
      for (int k = 0; k < 200 && falls.size() < 2; k++) tick(1);
      chk("clamp_starts", falls.size(), 2);
      if (falls.size() >= 2) begin
         chk("clamp_first_start", falls[0] - c0, 2);
         chk("clamp_frame_len", falls[1] - falls[0], 40);
      end
      for (int k = 0; k < 200 && !idle; k++) tick(1);
      chk("clamp_idle", 32'(idle), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
